// File: rtl/eth_tx_pkg.sv
// Shared definitions for the Ethernet frame transmit streamer.
package eth_tx_pkg;

    localparam int MAC_W   = 48;
    localparam int ETYPE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HDR    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } tx_state_t;

endpackage

// File: rtl/tx_beat_counter.sv
// Payload beat index with terminal-beat compare against the latched length.
module tx_beat_counter
    import eth_tx_pkg::*;
#(
    parameter int LEN_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] idx,
    output logic             is_last
);

    // Beat index: cleared when a frame is accepted, stepped on every payload fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (advance) begin
            idx <= idx + LEN_W'(1);
        end
    end

    // The beat at index len-1 is the natural end of the frame.
    always_comb begin
        is_last = (idx == (len - LEN_W'(1)));
    end

endmodule

// File: rtl/eth_frame_tx_stream.sv
// Streams an Ethernet header followed by len payload beats read from a
// synchronous-read byte buffer, with an abort path that ends the frame early
// with tuser set.
//
// state  | meaning
// IDLE   | waiting for start; start_ready high
// HDR    | presenting latched header fields until s_eth_hdr_ready
// STREAM | presenting payload beats straight from mem_rdata
// DONE   | one-cycle done pulse, done_err qualifies it
module eth_frame_tx_stream
    import eth_tx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               start,
    output logic               start_ready,
    input  logic [ADDR_W-1:0]  base,
    input  logic [LEN_W-1:0]   len,
    input  logic [MAC_W-1:0]   dest_mac,
    input  logic [MAC_W-1:0]   src_mac,
    input  logic [ETYPE_W-1:0] eth_type,
    input  logic               abort,

    output logic               s_eth_hdr_valid,
    input  logic               s_eth_hdr_ready,
    output logic [MAC_W-1:0]   s_eth_dest_mac,
    output logic [MAC_W-1:0]   s_eth_src_mac,
    output logic [ETYPE_W-1:0] s_eth_type,

    output logic [DATA_W-1:0]  s_eth_payload_axis_tdata,
    output logic               s_eth_payload_axis_tvalid,
    output logic               s_eth_payload_axis_tlast,
    output logic               s_eth_payload_axis_tuser,
    input  logic               s_eth_payload_axis_tready,

    output logic [ADDR_W-1:0]  mem_raddr,
    input  logic [DATA_W-1:0]  mem_rdata,

    output logic               done,
    output logic               done_err
);

    tx_state_t         state;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic              abort_sticky;
    logic              err_q;

    logic              accept;
    logic              in_hdr;
    logic              in_stream;
    logic              abort_hit;
    logic              fire;
    logic              last_beat;
    logic [LEN_W-1:0]  idx;
    logic              is_last;

    tx_beat_counter #(
        .LEN_W (LEN_W)
    ) u_beat_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .advance (fire),
        .len     (len_q),
        .idx     (idx),
        .is_last (is_last)
    );

    // Handshake decode; payload qualifiers come straight from state so they
    // stay stable across tready stalls.
    always_comb begin
        in_hdr      = (state == ST_HDR);
        in_stream   = (state == ST_STREAM);
        start_ready = (state == ST_IDLE);
        accept      = start & start_ready;
        abort_hit   = in_stream & (abort | abort_sticky);
        last_beat   = is_last | abort_hit;
        fire        = in_stream & s_eth_payload_axis_tready;
    end

    // Output mapping; the read address looks one beat ahead on a fire so the
    // buffer latency is hidden and a beat can leave every cycle.
    always_comb begin
        s_eth_hdr_valid           = in_hdr;
        s_eth_payload_axis_tvalid = in_stream;
        s_eth_payload_axis_tdata  = in_stream ? mem_rdata : '0;
        s_eth_payload_axis_tlast  = in_stream & last_beat;
        s_eth_payload_axis_tuser  = abort_hit;
        mem_raddr                 = base_q + ADDR_W'(idx) + ADDR_W'(fire);
        done                      = (state == ST_DONE);
        done_err                  = (state == ST_DONE) & err_q;
    end

    // Frame parameters and header fields captured when a non-empty frame starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q         <= '0;
            len_q          <= '0;
            s_eth_dest_mac <= '0;
            s_eth_src_mac  <= '0;
            s_eth_type     <= '0;
        end else if (accept && (len != '0)) begin
            base_q         <= base;
            len_q          <= len;
            s_eth_dest_mac <= dest_mac;
            s_eth_src_mac  <= src_mac;
            s_eth_type     <= eth_type;
        end
    end

    // Abort is remembered from HDR onward so the first beat can carry it, and
    // so a stalled beat keeps its tlast/tuser once abort has been seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            abort_sticky <= 1'b0;
            err_q        <= 1'b0;
        end else if (accept) begin
            abort_sticky <= 1'b0;
            err_q        <= (len == '0);
        end else if (abort && (in_hdr || in_stream)) begin
            abort_sticky <= 1'b1;
            err_q        <= 1'b1;
        end
    end

    // Frame sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= (len == '0) ? ST_DONE : ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (s_eth_hdr_ready) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (fire && last_beat) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_tx_stream.sv
// Bench for eth_frame_tx_stream: table of frame requests, scoreboard queues of
// expected beats and done flags, plus hand-written reset sequences.
module tb_eth_frame_tx_stream;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              start_ready;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [47:0]       dest_mac;
    logic [47:0]       src_mac;
    logic [15:0]       eth_type;
    logic              abort;
    logic              s_eth_hdr_valid;
    logic              s_eth_hdr_ready;
    logic [47:0]       s_eth_dest_mac;
    logic [47:0]       s_eth_src_mac;
    logic [15:0]       s_eth_type;
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tuser;
    logic              tready;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              done;
    logic              done_err;

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];

    // Synchronous-read buffer model.
    always @(posedge clk) mem_rdata <= mem[mem_raddr];

    eth_frame_tx_stream #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .start_ready               (start_ready),
        .base                      (base),
        .len                       (len),
        .dest_mac                  (dest_mac),
        .src_mac                   (src_mac),
        .eth_type                  (eth_type),
        .abort                     (abort),
        .s_eth_hdr_valid           (s_eth_hdr_valid),
        .s_eth_hdr_ready           (s_eth_hdr_ready),
        .s_eth_dest_mac            (s_eth_dest_mac),
        .s_eth_src_mac             (s_eth_src_mac),
        .s_eth_type                (s_eth_type),
        .s_eth_payload_axis_tdata  (tdata),
        .s_eth_payload_axis_tvalid (tvalid),
        .s_eth_payload_axis_tlast  (tlast),
        .s_eth_payload_axis_tuser  (tuser),
        .s_eth_payload_axis_tready (tready),
        .mem_raddr                 (mem_raddr),
        .mem_rdata                 (mem_rdata),
        .done                      (done),
        .done_err                  (done_err)
    );

    // abort_mode: 0 none, 1 during header, 2 while beat abort_beat is presented
    typedef struct {
        logic [7:0]  base;
        logic [8:0]  len;
        logic [15:0] pat;
        int          hstall;
        int          abort_mode;
        int          abort_beat;
        int          exp_beats;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    vec_t  vecs [10];
    beat_t exp_q [$];
    logic  exp_done_q [$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic        start_req;
    logic [15:0] cur_pat;
    int          cur_hstall;
    int          cur_abort_mode;
    int          cur_abort_beat;
    int          hwait;
    int          sidx;
    int          beats_fired;
    logic        got_done;
    logic        hdr_seen;
    int          t_start, t_hdr1, t_hdr_hs, t_first, t_last, t_done;
    logic [47:0] exp_dest, exp_src;
    logic [15:0] exp_type;

    logic        p_tvalid, p_tready, p_tlast, p_tuser, p_hvalid, p_hready;
    logic [7:0]  p_tdata, p_raddr;
    logic [47:0] p_dest, p_src;
    logic [15:0] p_type;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic miss(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event not expected by scoreboard (cycle %0d)", name, cyc);
    endtask

    task automatic clear_prev();
        p_tvalid = 0; p_tready = 0; p_tlast = 0; p_tuser = 0;
        p_hvalid = 0; p_hready = 0; p_tdata = 0; p_raddr = 0;
        p_dest = 0; p_src = 0; p_type = 0;
    endtask

    task automatic drive_inputs();
        start = start_req;
        abort = 1'b0;
        if (cur_abort_mode == 1 && s_eth_hdr_valid && hwait == 0) abort = 1'b1;
        if (cur_abort_mode == 2 && tvalid && beats_fired == cur_abort_beat) abort = 1'b1;
        if (s_eth_hdr_valid) begin
            s_eth_hdr_ready = (hwait >= cur_hstall);
            hwait++;
        end else begin
            s_eth_hdr_ready = 1'b0;
        end
        if (tvalid) begin
            tready = (sidx < 16) ? cur_pat[sidx] : 1'b1;
            sidx++;
        end else begin
            tready = 1'b0;
        end
    endtask

    task automatic monitor();
        beat_t b;
        logic  e;
        if (start && start_ready) begin
            t_start   = cyc;
            start_req = 1'b0;
        end
        if (s_eth_hdr_valid && !hdr_seen) begin
            hdr_seen = 1'b1;
            t_hdr1   = cyc;
            chk("hdr_dest", s_eth_dest_mac, exp_dest);
            chk("hdr_src", s_eth_src_mac, exp_src);
            chk("hdr_type", s_eth_type, exp_type);
        end
        if (s_eth_hdr_valid && s_eth_hdr_ready) t_hdr_hs = cyc;
        if (tvalid) chk("hdr_payload_overlap", s_eth_hdr_valid, 0);
        if (p_hvalid && !p_hready) begin
            chk("hdr_hold_valid", s_eth_hdr_valid, 1);
            chk("hdr_hold_dest", s_eth_dest_mac, p_dest);
            chk("hdr_hold_type", s_eth_type, p_type);
        end
        if (p_tvalid && !p_tready) begin
            chk("stall_tvalid", tvalid, 1);
            chk("stall_tdata", tdata, p_tdata);
            chk("stall_tlast", tlast, p_tlast);
            chk("stall_tuser", tuser, p_tuser);
            if (tvalid && !tready) chk("stall_raddr", mem_raddr, p_raddr);
        end
        if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
                miss("extra_beat");
            end else begin
                b = exp_q.pop_front();
                chk("beat_data", tdata, b.data);
                chk("beat_last", tlast, b.last);
                chk("beat_user", tuser, b.user);
            end
            if (beats_fired == 0) t_first = cyc;
            if (tlast) t_last = cyc;
            beats_fired++;
        end
        if (done) begin
            got_done = 1'b1;
            t_done   = cyc;
            if (exp_done_q.size() == 0) begin
                miss("extra_done");
            end else begin
                e = exp_done_q.pop_front();
                chk("done_err", done_err, e);
            end
        end
        p_tvalid = tvalid; p_tready = tready; p_tlast = tlast; p_tuser = tuser;
        p_tdata = tdata; p_raddr = mem_raddr;
        p_hvalid = s_eth_hdr_valid; p_hready = s_eth_hdr_ready;
        p_dest = s_eth_dest_mac; p_src = s_eth_src_mac; p_type = s_eth_type;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
        @(negedge clk);
        monitor();
    endtask

    task automatic check_reset_values();
        chk("rst_start_ready", start_ready, 1);
        chk("rst_hdr_valid", s_eth_hdr_valid, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tuser", tuser, 0);
        chk("rst_done", done, 0);
        chk("rst_done_err", done_err, 0);
        chk("rst_raddr", mem_raddr, 0);
        chk("rst_dest", s_eth_dest_mac, 0);
        chk("rst_src", s_eth_src_mac, 0);
        chk("rst_type", s_eth_type, 0);
    endtask

    task automatic setup_frame(input vec_t v, input int vi);
        logic [7:0] a;
        base     = v.base;
        len      = v.len;
        dest_mac = 48'h02_11_22_33_44_00 | 48'(vi);
        src_mac  = 48'h0A_BB_CC_DD_EE_00 | 48'(vi);
        eth_type = 16'h0800 + 16'(vi);
        exp_dest = dest_mac;
        exp_src  = src_mac;
        exp_type = eth_type;
        cur_pat        = v.pat;
        cur_hstall     = v.hstall;
        cur_abort_mode = v.abort_mode;
        cur_abort_beat = v.abort_beat;
        for (int k = 0; k < v.exp_beats; k++) begin
            beat_t b;
            a      = v.base + 8'(k);
            b.data = mem[a];
            b.last = (k == v.exp_beats - 1);
            b.user = v.exp_err && (k == v.exp_beats - 1);
            exp_q.push_back(b);
        end
        exp_done_q.push_back(v.exp_err);
        start_req   = 1'b1;
        hwait       = 0;
        sidx        = 0;
        beats_fired = 0;
        got_done    = 1'b0;
        hdr_seen    = 1'b0;
        t_start = -1; t_hdr1 = -1; t_hdr_hs = -1; t_first = -1; t_last = -1; t_done = -1;
    endtask

    task automatic run_frame(input vec_t v, input int vi);
        setup_frame(v, vi);
        for (int i = 0; i < 400 && !got_done; i++) cycle();
        if (!got_done) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_timeout vec %0d: done not seen, required within 400 cycles", vi);
        end
        cycle();
        chk("start_ready_back", start_ready, 1);
        chk("beats_left", exp_q.size(), 0);
        chk("beat_count", beats_fired, v.exp_beats);
        if (v.len == 0) begin
            chk("zero_no_hdr", hdr_seen, 0);
            chk("zero_done_lat", t_done, t_start + 1);
        end else begin
            chk("hdr_lat", t_hdr1, t_start + 1);
            chk("hdr_wait", t_hdr_hs - t_hdr1, v.hstall);
            if (v.pat[0]) chk("first_beat_lat", t_first, t_hdr_hs + 1);
            chk("done_lat", t_done, t_last + 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'((i * 13 + 7) & 255);
        for (int k = 0; k < 4; k++) mem[8'h10 + k] = 8'hA0 + 8'(k);

        //          base    len    tready pat  hstall abort beat nbeats err
        vecs[0] = '{8'h10, 9'd4,  16'hFFFF, 0, 0, 0, 4,  1'b0};
        vecs[1] = '{8'h20, 9'd3,  16'hFFF9, 0, 0, 0, 3,  1'b0};
        vecs[2] = '{8'hFE, 9'd4,  16'hFFFF, 0, 0, 0, 4,  1'b0};
        vecs[3] = '{8'h30, 9'd8,  16'hFFFF, 0, 2, 2, 3,  1'b1};
        vecs[4] = '{8'h00, 9'd0,  16'hFFFF, 0, 0, 0, 0,  1'b1};
        vecs[5] = '{8'h50, 9'd2,  16'hFFFF, 5, 0, 0, 2,  1'b0};
        vecs[6] = '{8'h60, 9'd3,  16'hFFFF, 0, 1, 0, 1,  1'b1};
        vecs[7] = '{8'h70, 9'd1,  16'hFFFF, 0, 0, 0, 1,  1'b0};
        vecs[8] = '{8'h80, 9'd5,  16'h5555, 0, 2, 3, 4,  1'b1};
        vecs[9] = '{8'hF8, 9'd20, 16'h3C3C, 2, 0, 0, 20, 1'b0};

        rst = 1'b1; start = 0; base = 0; len = 0; dest_mac = 0; src_mac = 0;
        eth_type = 0; abort = 0; s_eth_hdr_ready = 0; tready = 0;
        start_req = 0; cur_pat = 16'hFFFF; cur_hstall = 0; cur_abort_mode = 0;
        cur_abort_beat = 0; hwait = 0; sidx = 0; beats_fired = 0;
        got_done = 0; hdr_seen = 0; exp_dest = 0; exp_src = 0; exp_type = 0;
        t_start = -1; t_hdr1 = -1; t_hdr_hs = -1; t_first = -1; t_last = -1; t_done = -1;
        clear_prev();

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values();

        for (int v = 0; v < 10; v++) run_frame(vecs[v], v);

        // Reset in the middle of a frame, after beats 0 and 1 have gone out.
        setup_frame('{8'h40, 9'd8, 16'hFFFF, 0, 0, 0, 8, 1'b0}, 10);
        for (int i = 0; i < 40 && beats_fired < 2; i++) cycle();
        chk("pre_reset_beats", beats_fired, 2);
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b1; start = 0; abort = 0; tready = 0; s_eth_hdr_ready = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values();
        exp_q.delete();
        exp_done_q.delete();
        clear_prev();

        // A fresh frame must be accepted after the abandoned one.
        run_frame(vecs[0], 11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
